// File: rtl/fb_pkg.sv
// Shared types and polarity constants for the frame-buffer Avalon port.
package fb_pkg;

    // Read-side frame state: issuing reads, or waiting for the frame's last return.
    typedef enum logic {
        RD_ISSUE = 1'b0,
        RD_DRAIN = 1'b1
    } rd_state_t;

    // Named levels for active-low enables and active-high flags.
    localparam logic ASSERT_L   = 1'b0;
    localparam logic DEASSERT_L = 1'b1;
    localparam logic ASSERT_H   = 1'b1;
    localparam logic DEASSERT_H = 1'b0;

endpackage

// File: rtl/fb_rd_tracker.sv
// Read-return bookkeeping: outstanding count, returned-word count, frame FSM,
// registered read data, end-of-frame pulse and sticky stray-return error.
module fb_rd_tracker
    import fb_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int FRAME_WORDS    = 307200,
    parameter int MAX_RD_PENDING = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_rd_acc,
    input  logic                  i_rd_iss_last,
    input  logic                  i_mem_rdata_valid,
    input  logic [DATA_WIDTH-1:0] i_mem_rdata,
    output logic                  o_rd_allow,
    output logic [DATA_WIDTH-1:0] o_rd_data,
    output logic                  o_rd_data_valid,
    output logic                  o_rd_done,
    output logic                  o_err
);

    localparam int RET_W  = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
    localparam int PEND_W = $clog2(MAX_RD_PENDING + 1);
    localparam logic [RET_W-1:0]  RET_LAST = RET_W'(FRAME_WORDS - 1);
    localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(MAX_RD_PENDING);

    logic [PEND_W-1:0]     r_rd_pend;
    logic [RET_W-1:0]      r_rd_ret;
    rd_state_t             r_state;
    rd_state_t             w_state_nxt;
    logic [DATA_WIDTH-1:0] r_rd_data;
    logic                  r_rd_data_valid;
    logic                  r_rd_done;
    logic                  r_err;
    logic                  w_ret_ok;
    logic                  w_ret_stray;
    logic                  w_ret_last;

    assign w_ret_ok    = i_mem_rdata_valid & (r_rd_pend != '0);
    assign w_ret_stray = i_mem_rdata_valid & (r_rd_pend == '0);
    assign w_ret_last  = w_ret_ok & (r_rd_ret == RET_LAST);
    assign o_rd_allow  = (r_state == RD_ISSUE) & (r_rd_pend < PEND_MAX);

    assign o_rd_data       = r_rd_data;
    assign o_rd_data_valid = r_rd_data_valid;
    assign o_rd_done       = r_rd_done;
    assign o_err           = r_err;

    // Read FSM state register.
    always_ff @(posedge clk) begin
        if (reset) r_state <= RD_ISSUE;
        else       r_state <= w_state_nxt;
    end

    // Read FSM next state: stop issuing after the frame's last read, resume after its last return.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            RD_ISSUE: if (i_rd_acc && i_rd_iss_last) w_state_nxt = RD_DRAIN;
            RD_DRAIN: if (w_ret_last)                w_state_nxt = RD_ISSUE;
            default:                                 w_state_nxt = RD_ISSUE;
        endcase
    end

    // Outstanding and returned-word counters; an accept and a return in one cycle cancel.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_pend <= '0;
            r_rd_ret  <= '0;
        end else begin
            case ({i_rd_acc, w_ret_ok})
                2'b10:   r_rd_pend <= r_rd_pend + PEND_W'(1);
                2'b01:   r_rd_pend <= r_rd_pend - PEND_W'(1);
                default: r_rd_pend <= r_rd_pend;
            endcase
            if (w_ret_ok) r_rd_ret <= w_ret_last ? '0 : r_rd_ret + RET_W'(1);
        end
    end

    // Registered return data, end-of-frame pulse and sticky stray-return flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_data       <= '0;
            r_rd_data_valid <= DEASSERT_H;
            r_rd_done       <= DEASSERT_H;
            r_err           <= DEASSERT_H;
        end else begin
            r_rd_data_valid <= w_ret_ok;
            r_rd_done       <= w_ret_last;
            if (w_ret_ok)    r_rd_data <= i_mem_rdata;
            if (w_ret_stray) r_err     <= ASSERT_H;
        end
    end

endmodule

// File: rtl/fb_avl_port.sv
// Single frame-buffer Avalon-MM master: arbitrates single-word writes and reads
// at linear frame addresses; read returns are tracked in fb_rd_tracker.
module fb_avl_port
    import fb_pkg::*;
#(
    parameter int          ADDR_WIDTH     = 29,
    parameter int          DATA_WIDTH     = 32,
    parameter int unsigned BASE_ADDR      = 0,
    parameter int          FRAME_WORDS    = 307200,
    parameter int          MAX_RD_PENDING = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic                  avl_ready,
    output logic                  full,
    output logic                  rd_done,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_data_valid,
    output logic                  err,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_write,
    output logic                  mem_read,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ready,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_rdata_valid
);

    localparam int PTR_W = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
    localparam logic [PTR_W-1:0]      PTR_LAST = PTR_W'(FRAME_WORDS - 1);
    localparam logic [ADDR_WIDTH-1:0] BASE     = ADDR_WIDTH'(BASE_ADDR);

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_iss;
    logic             r_last_wr;
    logic             r_full;
    logic             w_rd_allow;
    logic             w_wr_elig;
    logic             w_rd_elig;
    logic             w_wr_gnt;
    logic             w_rd_gnt;
    logic             w_wr_acc;
    logic             w_rd_acc;

    // Both sides eligible: write wins unless the last accepted command was a write.
    assign w_wr_elig = (wr_en == ASSERT_L);
    assign w_rd_elig = (rd_en == ASSERT_L) & w_rd_allow;
    assign w_wr_gnt  = w_wr_elig & (~w_rd_elig | ~r_last_wr);
    assign w_rd_gnt  = w_rd_elig & ~w_wr_gnt;
    assign w_wr_acc  = w_wr_gnt & mem_ready;
    assign w_rd_acc  = w_rd_gnt & mem_ready;

    assign mem_write = w_wr_gnt;
    assign mem_read  = w_rd_gnt;
    assign mem_wdata = wr_data;
    assign mem_addr  = BASE + ADDR_WIDTH'(w_rd_gnt ? r_rd_iss : r_wr_ptr);
    assign avl_ready = mem_ready & ~w_rd_gnt;
    assign full      = r_full;

    // Frame pointers and arbitration history advance only on accepted commands.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr  <= '0;
            r_rd_iss  <= '0;
            r_last_wr <= DEASSERT_H;
            r_full    <= DEASSERT_H;
        end else begin
            r_full <= w_wr_acc & (r_wr_ptr == PTR_LAST);
            if (w_wr_acc) r_wr_ptr <= (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + PTR_W'(1);
            if (w_rd_acc) r_rd_iss <= (r_rd_iss == PTR_LAST) ? '0 : r_rd_iss + PTR_W'(1);
            if (w_wr_acc)      r_last_wr <= ASSERT_H;
            else if (w_rd_acc) r_last_wr <= DEASSERT_H;
        end
    end

    fb_rd_tracker #(
        .DATA_WIDTH     (DATA_WIDTH),
        .FRAME_WORDS    (FRAME_WORDS),
        .MAX_RD_PENDING (MAX_RD_PENDING)
    ) u_rd_tracker (
        .clk               (clk),
        .reset             (reset),
        .i_rd_acc          (w_rd_acc),
        .i_rd_iss_last     (r_rd_iss == PTR_LAST),
        .i_mem_rdata_valid (mem_rdata_valid),
        .i_mem_rdata       (mem_rdata),
        .o_rd_allow        (w_rd_allow),
        .o_rd_data         (rd_data),
        .o_rd_data_valid   (rd_data_valid),
        .o_rd_done         (rd_done),
        .o_err             (err)
    );

endmodule

// File: tb/tb_fb_avl_port.sv
// Self-checking bench for fb_avl_port with a 5-cycle fixed-latency memory model.
module tb_fb_avl_port;

    localparam int AW = 29, DW = 32, FW = 16, MAXP = 4, LAT = 5;
    localparam logic [AW-1:0] BASE = 29'h100;

    logic          clk = 1'b0;
    logic          reset, wr_en, rd_en, mem_ready, mem_rdata_valid;
    logic [DW-1:0] wr_data, mem_rdata;
    logic          avl_ready, full, rd_done, rd_data_valid, err, mem_write, mem_read;
    logic [DW-1:0] rd_data, mem_wdata;
    logic [AW-1:0] mem_addr;

    always #5 clk = ~clk;

    fb_avl_port #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BASE_ADDR(256),
        .FRAME_WORDS(FW), .MAX_RD_PENDING(MAXP)
    ) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .avl_ready(avl_ready), .full(full), .rd_done(rd_done), .rd_data(rd_data),
        .rd_data_valid(rd_data_valid), .err(err), .mem_addr(mem_addr),
        .mem_write(mem_write), .mem_read(mem_read), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata), .mem_rdata_valid(mem_rdata_valid)
    );

    int n_cmp = 0, n_fail = 0;

    // memory model
    logic [DW-1:0] mem [logic [AW-1:0]];
    logic          pipe_v [LAT];
    logic [DW-1:0] pipe_d [LAT];
    int            max_out;

    // reference model state
    int m_wr_ptr, m_rd_iss, m_pend, m_ret;
    bit m_drain, m_last_wr;
    logic [DW-1:0] exp_q [$];

    // expected values and observed pre-edge command signals
    logic          e_write, e_read, e_avl, e_full, e_rd_done, e_rdv, e_err;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_rdata;
    logic          c_write, c_read, c_avl;
    logic [AW-1:0] c_addr;
    logic [DW-1:0] c_wdata;

    function automatic logic [DW-1:0] mem_rd(input logic [AW-1:0] a);
        if (mem.exists(a)) return mem[a];
        return {3'b000, a} ^ 32'h5A5A_0000;
    endfunction

    // One clock cycle: caller has set inputs; predicts commands, samples them, clocks, updates model.
    task automatic tick();
        bit wel, rel, wacc, racc, ret_ok;
        int outstanding;
        mem_rdata_valid = pipe_v[0];
        mem_rdata       = pipe_d[0];
        wel     = (wr_en == 1'b0);
        rel     = (rd_en == 1'b0) && !m_drain && (m_pend < MAXP);
        e_write = wel && (!rel || !m_last_wr);
        e_read  = rel && !e_write;
        e_avl   = mem_ready && !e_read;
        e_addr  = BASE + AW'(e_read ? m_rd_iss : m_wr_ptr);
        #1;
        c_write = mem_write; c_read = mem_read; c_avl = avl_ready;
        c_addr  = mem_addr;  c_wdata = mem_wdata;
        @(posedge clk);
        for (int i = 0; i < LAT - 1; i++) begin
            pipe_v[i] = pipe_v[i+1];
            pipe_d[i] = pipe_d[i+1];
        end
        pipe_v[LAT-1] = 1'b0;
        if (c_write && mem_ready) mem[c_addr] = c_wdata;
        if (c_read && mem_ready) begin
            pipe_v[LAT-1] = 1'b1;
            pipe_d[LAT-1] = mem_rd(c_addr);
        end
        outstanding = 0;
        for (int i = 0; i < LAT; i++) if (pipe_v[i]) outstanding++;
        if (outstanding > max_out) max_out = outstanding;
        wacc = e_write && mem_ready;
        racc = e_read && mem_ready;
        if (reset) begin
            m_wr_ptr = 0; m_rd_iss = 0; m_pend = 0; m_ret = 0;
            m_drain = 0; m_last_wr = 0; exp_q.delete();
            e_full = 0; e_rd_done = 0; e_rdv = 0; e_err = 0; e_rdata = '0;
        end else begin
            ret_ok    = mem_rdata_valid && (m_pend > 0);
            e_rdv     = ret_ok;
            e_rd_done = ret_ok && (m_ret == FW - 1);
            e_full    = wacc && (m_wr_ptr == FW - 1);
            if (mem_rdata_valid && m_pend == 0) e_err = 1'b1;
            if (ret_ok) begin
                if (exp_q.size() > 0) e_rdata = exp_q.pop_front();
                if (m_ret == FW - 1) m_drain = 0;
                m_ret = (m_ret + 1) % FW;
                m_pend--;
            end
            if (racc) begin
                exp_q.push_back(mem_rd(BASE + AW'(m_rd_iss)));
                if (m_rd_iss == FW - 1) m_drain = 1;
                m_rd_iss = (m_rd_iss + 1) % FW;
                m_pend++;
            end
            if (wacc) m_wr_ptr = (m_wr_ptr + 1) % FW;
            if (wacc) m_last_wr = 1;
            else if (racc) m_last_wr = 0;
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1; wr_en = 1; rd_en = 1; mem_ready = 1; wr_data = '0;
        tick(); tick();
        n_cmp++; if (full !== 1'b0) begin n_fail++; $display("FAIL rst_full: got %b exp 0", full); end
        n_cmp++; if (rd_done !== 1'b0) begin n_fail++; $display("FAIL rst_rd_done: got %b exp 0", rd_done); end
        n_cmp++; if (rd_data_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rdv: got %b exp 0", rd_data_valid); end
        n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b exp 0", err); end
        n_cmp++; if (rd_data !== '0) begin n_fail++; $display("FAIL rst_rd_data: got %h exp 0", rd_data); end
        n_cmp++; if (mem_write !== 1'b0 || mem_read !== 1'b0) begin n_fail++; $display("FAIL rst_cmd: got w%b r%b exp w0 r0", mem_write, mem_read); end
        n_cmp++; if (mem_addr !== BASE) begin n_fail++; $display("FAIL rst_addr: got %h exp %h", mem_addr, BASE); end
        reset = 0;
        tick();
    endtask

    task automatic test_write_frame();
        logic [DW-1:0] src [FW];
        int fulls = 0;
        for (int i = 0; i < FW; i++) begin
            wr_en = 0; wr_data = $urandom; src[i] = wr_data;
            tick();
            n_cmp++; if (c_write !== 1'b1) begin n_fail++; $display("FAIL wf_write[%0d]: got %b exp 1", i, c_write); end
            n_cmp++; if (c_addr !== BASE + AW'(i)) begin n_fail++; $display("FAIL wf_addr[%0d]: got %h exp %h", i, c_addr, BASE + AW'(i)); end
            n_cmp++; if (c_wdata !== src[i]) begin n_fail++; $display("FAIL wf_wdata[%0d]: got %h exp %h", i, c_wdata, src[i]); end
            n_cmp++; if (full !== e_full) begin n_fail++; $display("FAIL wf_full[%0d]: got %b exp %b", i, full, e_full); end
            if (full === 1'b1) fulls++;
        end
        n_cmp++; if (full !== 1'b1) begin n_fail++; $display("FAIL wf_full_last: got %b exp 1", full); end
        wr_en = 1;
        tick();
        n_cmp++; if (full !== 1'b0) begin n_fail++; $display("FAIL wf_full_width: got %b exp 0", full); end
        n_cmp++; if (fulls != 1) begin n_fail++; $display("FAIL wf_full_count: got %0d exp 1", fulls); end
        n_cmp++; if (mem_addr !== BASE) begin n_fail++; $display("FAIL wf_ptr_wrap: got %h exp %h", mem_addr, BASE); end
        for (int i = 0; i < FW; i++) begin
            n_cmp++; if (mem_rd(BASE + AW'(i)) !== src[i]) begin n_fail++; $display("FAIL wf_mem[%0d]: got %h exp %h", i, mem_rd(BASE + AW'(i)), src[i]); end
        end
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] src [FW];
        logic [AW-1:0] held_a;
        logic [DW-1:0] held_d;
        int idx = 0, fulls = 0;
        for (int i = 0; i < FW; i++) src[i] = $urandom;
        for (int cyc = 0; cyc < 40 && idx < FW; cyc++) begin
            wr_en = 0; wr_data = src[idx];
            mem_ready = (cyc >= 5 && cyc < 8) ? 1'b0 : 1'b1;
            tick();
            n_cmp++; if (c_avl !== e_avl) begin n_fail++; $display("FAIL bp_avl[%0d]: got %b exp %b", cyc, c_avl, e_avl); end
            n_cmp++; if (c_addr !== e_addr) begin n_fail++; $display("FAIL bp_addr[%0d]: got %h exp %h", cyc, c_addr, e_addr); end
            if (cyc == 5) begin held_a = c_addr; held_d = c_wdata; end
            if (cyc > 5 && cyc <= 8) begin
                n_cmp++; if (c_addr !== held_a || c_wdata !== held_d) begin n_fail++; $display("FAIL bp_hold[%0d]: got %h/%h exp %h/%h", cyc, c_addr, c_wdata, held_a, held_d); end
            end
            if (full === 1'b1) fulls++;
            if (c_avl === 1'b1) idx++;
        end
        wr_en = 1; mem_ready = 1;
        tick();
        if (full === 1'b1) fulls++;
        n_cmp++; if (fulls != 1) begin n_fail++; $display("FAIL bp_full_count: got %0d exp 1", fulls); end
        for (int i = 0; i < FW; i++) begin
            n_cmp++; if (mem_rd(BASE + AW'(i)) !== src[i]) begin n_fail++; $display("FAIL bp_mem[%0d]: got %h exp %h", i, mem_rd(BASE + AW'(i)), src[i]); end
        end
    endtask

    task automatic test_pending_limit();
        int nreads = 0, nvalid = 0;
        bit done = 0;
        max_out = 0;
        wr_en = 1; rd_en = 0; mem_ready = 1;
        for (int cyc = 0; cyc < 120 && !done; cyc++) begin
            tick();
            if (c_read === 1'b1) nreads++;
            if (rd_data_valid === 1'b1) nvalid++;
            n_cmp++; if (c_read !== e_read) begin n_fail++; $display("FAIL pl_read[%0d]: got %b exp %b", cyc, c_read, e_read); end
            if (e_read) begin
                n_cmp++; if (c_addr !== e_addr) begin n_fail++; $display("FAIL pl_addr[%0d]: got %h exp %h", cyc, c_addr, e_addr); end
            end
            n_cmp++; if (rd_data_valid !== e_rdv) begin n_fail++; $display("FAIL pl_rdv[%0d]: got %b exp %b", cyc, rd_data_valid, e_rdv); end
            if (e_rdv) begin
                n_cmp++; if (rd_data !== e_rdata) begin n_fail++; $display("FAIL pl_data[%0d]: got %h exp %h", cyc, rd_data, e_rdata); end
            end
            n_cmp++; if (rd_done !== e_rd_done) begin n_fail++; $display("FAIL pl_rd_done[%0d]: got %b exp %b", cyc, rd_done, e_rd_done); end
            if (rd_done === 1'b1) begin
                done = 1;
                n_cmp++; if (nvalid != FW || rd_data_valid !== 1'b1) begin n_fail++; $display("FAIL pl_done_align: got %0d valid exp %0d", nvalid, FW); end
            end
        end
        rd_en = 1;
        n_cmp++; if (!done) begin n_fail++; $display("FAIL pl_timeout: got no rd_done exp rd_done"); end
        n_cmp++; if (nreads != FW) begin n_fail++; $display("FAIL pl_nreads: got %0d exp %0d", nreads, FW); end
        n_cmp++; if (max_out != MAXP) begin n_fail++; $display("FAIL pl_max_out: got %0d exp %0d", max_out, MAXP); end
        tick();
    endtask

    task automatic test_simultaneous();
        wr_en = 0; rd_en = 0; mem_ready = 1;
        for (int i = 0; i < 8; i++) begin
            wr_data = $urandom;
            tick();
            n_cmp++; if (c_write !== ((i % 2) == 0) || c_read !== ((i % 2) == 1)) begin n_fail++; $display("FAIL sim_grant[%0d]: got w%b r%b exp w%0d r%0d", i, c_write, c_read, (i % 2) == 0, (i % 2) == 1); end
            n_cmp++; if (c_avl !== !c_read) begin n_fail++; $display("FAIL sim_avl[%0d]: got %b exp %b", i, c_avl, !c_read); end
            n_cmp++; if (c_addr !== e_addr) begin n_fail++; $display("FAIL sim_addr[%0d]: got %h exp %h", i, c_addr, e_addr); end
        end
        wr_en = 1; rd_en = 1;
        for (int i = 0; i < 8; i++) begin
            tick();
            n_cmp++; if (rd_data_valid !== e_rdv) begin n_fail++; $display("FAIL sim_rdv[%0d]: got %b exp %b", i, rd_data_valid, e_rdv); end
            if (e_rdv) begin
                n_cmp++; if (rd_data !== e_rdata) begin n_fail++; $display("FAIL sim_data[%0d]: got %h exp %h", i, rd_data, e_rdata); end
            end
        end
    endtask

    task automatic test_reset_mid_read();
        int stale = 0;
        wr_en = 1; rd_en = 0; mem_ready = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++; if (c_read !== 1'b1) begin n_fail++; $display("FAIL rm_issue[%0d]: got %b exp 1", i, c_read); end
        end
        rd_en = 1; reset = 1;
        tick();
        reset = 0;
        n_cmp++; if (rd_data_valid !== 1'b0 || full !== 1'b0 || rd_done !== 1'b0 || err !== 1'b0) begin n_fail++; $display("FAIL rm_reset_outs: got v%b f%b d%b e%b exp all 0", rd_data_valid, full, rd_done, err); end
        n_cmp++; if (mem_addr !== BASE || rd_data !== '0) begin n_fail++; $display("FAIL rm_reset_addr: got %h/%h exp %h/0", mem_addr, rd_data, BASE); end
        for (int i = 0; i < 7; i++) begin
            tick();
            if (mem_rdata_valid === 1'b1) stale++;
            n_cmp++; if (rd_data_valid !== 1'b0) begin n_fail++; $display("FAIL rm_dropped[%0d]: got %b exp 0", i, rd_data_valid); end
            n_cmp++; if (err !== e_err) begin n_fail++; $display("FAIL rm_err[%0d]: got %b exp %b", i, err, e_err); end
        end
        n_cmp++; if (stale != 3 || err !== 1'b1) begin n_fail++; $display("FAIL rm_stale: got %0d returns err %b exp 3 err 1", stale, err); end
        wr_en = 0;
        tick();
        n_cmp++; if (c_write !== 1'b1 || c_addr !== BASE) begin n_fail++; $display("FAIL rm_next_wr: got w%b %h exp w1 %h", c_write, c_addr, BASE); end
        wr_en = 1; rd_en = 0;
        tick();
        n_cmp++; if (c_read !== 1'b1 || c_addr !== BASE) begin n_fail++; $display("FAIL rm_next_rd: got r%b %h exp r1 %h", c_read, c_addr, BASE); end
        rd_en = 1;
    endtask

    task automatic test_random();
        for (int cyc = 0; cyc < 320; cyc++) begin
            if (cyc < 300) begin
                wr_en = $urandom_range(0, 1); rd_en = $urandom_range(0, 1);
                mem_ready = ($urandom_range(0, 3) != 0); wr_data = $urandom;
            end else begin
                wr_en = 1; rd_en = 1; mem_ready = 1;
            end
            tick();
            n_cmp++; if (c_write !== e_write || c_read !== e_read) begin n_fail++; $display("FAIL rnd_cmd[%0d]: got w%b r%b exp w%b r%b", cyc, c_write, c_read, e_write, e_read); end
            n_cmp++; if (c_avl !== e_avl) begin n_fail++; $display("FAIL rnd_avl[%0d]: got %b exp %b", cyc, c_avl, e_avl); end
            if (e_write || e_read) begin
                n_cmp++; if (c_addr !== e_addr) begin n_fail++; $display("FAIL rnd_addr[%0d]: got %h exp %h", cyc, c_addr, e_addr); end
            end
            n_cmp++; if (full !== e_full || rd_done !== e_rd_done) begin n_fail++; $display("FAIL rnd_pulse[%0d]: got f%b d%b exp f%b d%b", cyc, full, rd_done, e_full, e_rd_done); end
            n_cmp++; if (rd_data_valid !== e_rdv) begin n_fail++; $display("FAIL rnd_rdv[%0d]: got %b exp %b", cyc, rd_data_valid, e_rdv); end
            if (e_rdv) begin
                n_cmp++; if (rd_data !== e_rdata) begin n_fail++; $display("FAIL rnd_data[%0d]: got %h exp %h", cyc, rd_data, e_rdata); end
            end
            n_cmp++; if (err !== e_err) begin n_fail++; $display("FAIL rnd_err[%0d]: got %b exp %b", cyc, err, e_err); end
        end
    endtask

    initial begin
        for (int i = 0; i < LAT; i++) begin pipe_v[i] = 1'b0; pipe_d[i] = '0; end
        reset = 1; wr_en = 1; rd_en = 1; mem_ready = 1; wr_data = '0;
        mem_rdata = '0; mem_rdata_valid = 0;
        m_wr_ptr = 0; m_rd_iss = 0; m_pend = 0; m_ret = 0; m_drain = 0; m_last_wr = 0;
        e_full = 0; e_rd_done = 0; e_rdv = 0; e_err = 0; e_rdata = '0; max_out = 0;
        @(posedge clk); #1;
        test_reset();
        test_write_frame();
        test_backpressure();
        test_pending_limit();
        test_simultaneous();
        test_reset_mid_read();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
